prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Top-level program scheduler for the single-cycle core. It launches the three benchmark programs (product, string match, closest pair) one at a time by loading the program counter with each program's start address. It gates core execution while a program runs and detects completion or timeout. It sits between the testbench/host handshake and the `pc` and core-enable logic, replacing the practice of treating successive reset pulses as program selectors.

## Interface
Parameters:
- `NUM_PROGS`, 3: number of programs sequenced, in index order 0..NUM_PROGS-1.
- `CNT_W`, 16: width of the run-cycle counter.
- `TIMEOUT`, 16'hFFFF: RUN cycles allowed before forced completion.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request to launch the next program; sampled in IDLE and FINISH only.
- `done`  in  1  core halt flag; sampled in RUN only.
- `pc_load`  out  1  one-cycle pulse; the PC loads `pc_start`.
- `pc_start`  out  8  start address of the current program.
- `prog_id`  out  2  index of the current or next program.
- `core_en`  out  1  core may advance the PC and commit state.
- `busy`  out  1  high in LOAD and RUN.
- `ack`  out  1  one-cycle pulse when a program completes.
- `timeout`  out  1  sticky; set when any program hit `TIMEOUT`.
- `all_done`  out  1  high in FINISH.
- `run_cycles`  out  CNT_W  cycle count of the last completed program (only when `SEQ_CYCLE_COUNT_EN` is defined).

## Operation
- States: IDLE, LOAD, RUN, FINISH (enum `seq_state_t`).
- Reset (`reset_n`=0 at a posedge) drives the following, regardless of current state, including mid-RUN:
  - state=IDLE, `prog_id`=0, `pc_start`=PROG0_START.
  - All other outputs 0, `timeout` cleared.
- IDLE:
  - `start`=1 → LOAD.
  - Otherwise hold.
- LOAD: lasts exactly one cycle.
  - `pc_load`=1, `core_en`=0, run counter cleared.
  - Always → RUN.
- RUN: `core_en`=1; the run counter increments every cycle, saturating at all-ones.
  - `done`=1 → `ack` pulse next cycle, `core_en`=0 next cycle, `prog_id` increments. Next state is FINISH if `prog_id` was NUM_PROGS-1, otherwise IDLE.
  - Counter reaches TIMEOUT-1 with `done`=0 → `timeout` set and completion handled exactly as for `done`.
  - `done` and timeout in the same cycle count as a single completion; `timeout` is still set.
  - `start` is ignored.
- FINISH:
  - `all_done`=1.
  - `start`=1 wraps: `prog_id`←0, `all_done` cleared, → LOAD. `timeout` is not cleared.
- `pc_start` is a combinational lookup of `prog_id`: 0→PROG0_START(0), 1→PROG1_START(25), 2→PROG2_START(44), 3→0.
- A single `start` pulse launches exactly one program. Holding `start` high launches programs back-to-back, one per IDLE visit.

## Timing
- `start` sampled high at edge T (in IDLE) → LOAD at T+1 (`pc_load`=1) → RUN at T+2 (`core_en`=1). The PC holds `pc_start` at the start of cycle T+2.
- `done` sampled high at edge D → `ack`=1 and `core_en`=0 during D+1, `prog_id` updated at D+1.
- Earliest relaunch: `start` seen at D+1 (IDLE) → `pc_load` at D+2.
- Minimum program turnaround, start to start, is 3 cycles.
- `run_cycles` counts RUN cycles including the `done` cycle. It is latched at D+1 and held until the next completion.

## Configuration
- `SEQ_CYCLE_COUNT_EN` defined: the `run_cycles` port exists and is driven as above.
- `SEQ_CYCLE_COUNT_EN` not defined: the port and its latch register are removed.
  - The internal run counter is still kept for the timeout.
  - All other behaviour is identical.

## Structure
- The `definitions` package gains:
  - `PROG0_START`/`PROG1_START`/`PROG2_START` (8-bit), shared with the `pc` block.
  - The `seq_state_t` enum.
- One sub-module, `seq_run_counter`: CNT_W saturating counter with clear, enable, and a terminal-count flag compared against `TIMEOUT`.

## Test plan
- Reset, then `start` pulse → `pc_load` one cycle later with `pc_start`=0 and `prog_id`=0; `core_en` high the following cycle.
- Program 0 runs 10 cycles, then `done` → `ack` one cycle later; `prog_id`=1, `run_cycles`=10, back to IDLE; next `start` gives `pc_start`=25.
- Run all three programs with `done` → third `ack`, then `all_done`=1 with `prog_id`=3. A further `start` gives `pc_start`=0 and clears `all_done`.
- `TIMEOUT`=8, `done` never asserted → `ack` after 8 RUN cycles, `timeout`=1 and stays set through the next program.
- Assert `reset_n`=0 mid-RUN of program 1 → next cycle state is IDLE, `prog_id`=0, `core_en`=0, `timeout`=0.
- In RUN, `start` and `done` high together → exactly one `ack` and no extra `pc_load`. With `start` held high afterwards, the next program loads exactly once.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer and the pc block:
// program start addresses, sequencer state encoding and the
// program-index to start-address lookup.
package definitions;

    localparam logic [7:0] PROG0_START = 8'd0;
    localparam logic [7:0] PROG1_START = 8'd25;
    localparam logic [7:0] PROG2_START = 8'd44;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    // Index 3 is the "all programs done" value and maps back to address 0.
    function automatic logic [7:0] prog_start_addr(input logic [1:0] id);
        case (id)
            2'd0:    return PROG0_START;
            2'd1:    return PROG1_START;
            2'd2:    return PROG2_START;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/prog_sequencer_run_counter.sv
// seq_run_counter: saturating run-cycle counter with synchronous clear,
// count enable and a terminal-count flag raised on the cycle the counter
// holds TIMEOUT-1 while enabled.
// The raw count is exported only when SEQ_CYCLE_COUNT_EN is defined.
module seq_run_counter #(
    parameter int          CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
`ifdef SEQ_CYCLE_COUNT_EN
    output logic [CNT_W-1:0] count_o,
`endif
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise increment and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == TC_VAL);

`ifdef SEQ_CYCLE_COUNT_EN
    assign count_o = count_q;
`endif

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches the benchmark programs one at a time by
// pulsing pc_load with each program's start address, gates the core
// while a program runs, and detects completion (done) or timeout.
// Optional feature: define SEQ_CYCLE_COUNT_EN to add the run_cycles
// port, holding the RUN-cycle count of the last completed program.
module prog_sequencer
    import definitions::*;
#(
    parameter int          NUM_PROGS = 3,
    parameter int          CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             done,
    output logic             pc_load,
    output logic [7:0]       pc_start,
    output logic [1:0]       prog_id,
    output logic             core_en,
    output logic             busy,
    output logic             ack,
    output logic             timeout,
    output logic             all_done
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] run_cycles
`endif
);

    localparam logic [1:0] LAST_ID = 2'(NUM_PROGS - 1);

    seq_state_t state_q, state_d;
    logic [1:0] prog_id_q, prog_id_d;
    logic       ack_q, ack_d;
    logic       timeout_q, timeout_d;
    logic       tc;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
`endif

    seq_run_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_run_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (state_q == LOAD),
        .en_i    (state_q == RUN),
`ifdef SEQ_CYCLE_COUNT_EN
        .count_o (count),
`endif
        .tc_o    (tc)
    );

    // Next-state logic; done and timeout together form one completion.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        prog_id_d = prog_id_q;
        ack_d     = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (done || tc) begin
                    ack_d     = 1'b1;
                    prog_id_d = prog_id_q + 1'b1;
                    if (tc) timeout_d = 1'b1;
                    state_d   = (prog_id_q == LAST_ID) ? FINISH : IDLE;
                end
            end
            FINISH: begin
                if (start) begin
                    prog_id_d = 2'd0;
                    state_d   = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins from any state, including mid-RUN.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q   <= IDLE;
            prog_id_q <= 2'd0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_id_q <= prog_id_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    // Capture the count including the completing cycle, saturated.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (ack_d) begin
            run_cycles_d = (count == '1) ? count : count + 1'b1;
        end
    end

    // Cycle-count latch, held until the next completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

    assign pc_load  = (state_q == LOAD);
    assign core_en  = (state_q == RUN);
    assign busy     = (state_q == LOAD) || (state_q == RUN);
    assign all_done = (state_q == FINISH);
    assign prog_id  = prog_id_q;
    assign pc_start = prog_start_addr(prog_id_q);
    assign ack      = ack_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer. Instance a uses the default TIMEOUT,
// instance b uses TIMEOUT=8; sel picks which one the tasks drive/observe.
module tb_prog_sequencer;

    import definitions::*;

    logic clk;
    logic sel;
    logic rst_a, start_a, done_a;
    logic rst_b, start_b, done_b;

    logic       pc_load_a, core_en_a, busy_a, ack_a, timeout_a, all_done_a;
    logic [7:0] pc_start_a;
    logic [1:0] prog_id_a;
    logic       pc_load_b, core_en_b, busy_b, ack_b, timeout_b, all_done_b;
    logic [7:0] pc_start_b;
    logic [1:0] prog_id_b;

    logic       o_pc_load, o_core_en, o_busy, o_ack, o_timeout, o_all_done;
    logic [7:0] o_pc_start;
    logic [1:0] o_prog_id;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] run_cycles_a, run_cycles_b, o_run_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    prog_sequencer dut_a (
        .clk        (clk),
        .reset_n    (rst_a),
        .start      (start_a),
        .done       (done_a),
        .pc_load    (pc_load_a),
        .pc_start   (pc_start_a),
        .prog_id    (prog_id_a),
        .core_en    (core_en_a),
        .busy       (busy_a),
        .ack        (ack_a),
        .timeout    (timeout_a),
        .all_done   (all_done_a)
`ifdef SEQ_CYCLE_COUNT_EN
        ,
        .run_cycles (run_cycles_a)
`endif
    );

    prog_sequencer #(.TIMEOUT(8)) dut_b (
        .clk        (clk),
        .reset_n    (rst_b),
        .start      (start_b),
        .done       (done_b),
        .pc_load    (pc_load_b),
        .pc_start   (pc_start_b),
        .prog_id    (prog_id_b),
        .core_en    (core_en_b),
        .busy       (busy_b),
        .ack        (ack_b),
        .timeout    (timeout_b),
        .all_done   (all_done_b)
`ifdef SEQ_CYCLE_COUNT_EN
        ,
        .run_cycles (run_cycles_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_pc_load  = sel ? pc_load_b  : pc_load_a;
        o_core_en  = sel ? core_en_b  : core_en_a;
        o_busy     = sel ? busy_b     : busy_a;
        o_ack      = sel ? ack_b      : ack_a;
        o_timeout  = sel ? timeout_b  : timeout_a;
        o_all_done = sel ? all_done_b : all_done_a;
        o_pc_start = sel ? pc_start_b : pc_start_a;
        o_prog_id  = sel ? prog_id_b  : prog_id_a;
`ifdef SEQ_CYCLE_COUNT_EN
        o_run_cycles = sel ? run_cycles_b : run_cycles_a;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_done(input logic v);
        if (sel) done_b = v; else done_a = v;
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // Single start pulse from IDLE/FINISH: LOAD next cycle, RUN after.
    task automatic launch(input logic [1:0] exp_id, input logic [7:0] exp_pc);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("load.pc_load", o_pc_load, 1);
        check("load.prog_id", o_prog_id, exp_id);
        check("load.pc_start", o_pc_start, exp_pc);
        check("load.core_en", o_core_en, 0);
        check("load.busy", o_busy, 1);
        tick();
        check("run.core_en", o_core_en, 1);
        check("run.pc_load", o_pc_load, 0);
    endtask

    // Called in RUN cycle 1: done is raised during RUN cycle n.
    task automatic run_for(input int n);
        repeat (n - 1) tick();
        set_done(1'b1);
        tick();
        set_done(1'b0);
    endtask

    initial begin
        sel = 1'b0;
        rst_a = 1'b0; start_a = 1'b0; done_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; done_b = 1'b0;
        tick();
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset state
        check("rst.pc_load", o_pc_load, 0);
        check("rst.pc_start", o_pc_start, 0);
        check("rst.prog_id", o_prog_id, 0);
        check("rst.core_en", o_core_en, 0);
        check("rst.busy", o_busy, 0);
        check("rst.ack", o_ack, 0);
        check("rst.timeout", o_timeout, 0);
        check("rst.all_done", o_all_done, 0);

        // Program 0 runs 10 cycles
        launch(2'd0, 8'd0);
        run_for(10);
        check("p0.ack", o_ack, 1);
        check("p0.core_en", o_core_en, 0);
        check("p0.prog_id", o_prog_id, 1);
        check("p0.busy", o_busy, 0);
        check("p0.pc_start", o_pc_start, 25);
`ifdef SEQ_CYCLE_COUNT_EN
        check("p0.run_cycles", o_run_cycles, 10);
`endif
        tick();
        check("p0.ack_pulse", o_ack, 0);
        check("p0.idle_load", o_pc_load, 0);

        // Program 1 runs 3 cycles
        launch(2'd1, 8'd25);
        run_for(3);
        check("p1.ack", o_ack, 1);
        check("p1.prog_id", o_prog_id, 2);
        check("p1.all_done", o_all_done, 0);
`ifdef SEQ_CYCLE_COUNT_EN
        check("p1.run_cycles", o_run_cycles, 3);
`endif

        // Program 2 completes in its first RUN cycle
        launch(2'd2, 8'd44);
        run_for(1);
        check("p2.ack", o_ack, 1);
        check("p2.prog_id", o_prog_id, 3);
        check("p2.all_done", o_all_done, 1);
        check("p2.pc_start", o_pc_start, 0);
        check("p2.timeout", o_timeout, 0);
`ifdef SEQ_CYCLE_COUNT_EN
        check("p2.run_cycles", o_run_cycles, 1);
`endif
        tick();
        check("fin.all_done_hold", o_all_done, 1);
        check("fin.ack", o_ack, 0);

        // Wrap from FINISH
        launch(2'd0, 8'd0);
        check("wrap.all_done", o_all_done, 0);

        // start and done together in RUN, start then held high
        set_start(1'b1);
        set_done(1'b1);
        tick();
        set_done(1'b0);
        check("sd.ack", o_ack, 1);
        check("sd.no_extra_load", o_pc_load, 0);
        check("sd.prog_id", o_prog_id, 1);
        tick();
        check("sd.reload", o_pc_load, 1);
        check("sd.single_ack", o_ack, 0);
        check("sd.pc_start", o_pc_start, 25);
        set_start(1'b0);
        tick();
        check("sd.run", o_core_en, 1);
        check("sd.load_once", o_pc_load, 0);

        // Timeout on instance b (TIMEOUT=8)
        sel = 1'b1;
        launch(2'd0, 8'd0);
        repeat (7) tick();
        check("to.before_ack", o_ack, 0);
        check("to.before_core_en", o_core_en, 1);
        check("to.before_flag", o_timeout, 0);
        tick();
        check("to.ack", o_ack, 1);
        check("to.flag", o_timeout, 1);
        check("to.prog_id", o_prog_id, 1);
        check("to.core_en", o_core_en, 0);
`ifdef SEQ_CYCLE_COUNT_EN
        check("to.run_cycles", o_run_cycles, 8);
`endif

        // Sticky timeout through the next program, then reset mid-RUN
        launch(2'd1, 8'd25);
        check("to.sticky", o_timeout, 1);
        tick();
        tick();
        set_rst(1'b0);
        tick();
        set_rst(1'b1);
        check("mrst.prog_id", o_prog_id, 0);
        check("mrst.core_en", o_core_en, 0);
        check("mrst.timeout", o_timeout, 0);
        check("mrst.busy", o_busy, 0);
        check("mrst.pc_start", o_pc_start, 0);
        check("mrst.ack", o_ack, 0);

        // done on the same cycle as the terminal count
        launch(2'd0, 8'd0);
        repeat (7) tick();
        set_done(1'b1);
        tick();
        set_done(1'b0);
        check("dt.ack", o_ack, 1);
        check("dt.flag", o_timeout, 1);
        check("dt.prog_id", o_prog_id, 1);
`ifdef SEQ_CYCLE_COUNT_EN
        check("dt.run_cycles", o_run_cycles, 8);
`endif
        tick();
        check("dt.single_ack", o_ack, 0);
        check("dt.busy", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
